// File: rtl/alu_pipe_pkg.sv
// Shared types and helpers for the pipelined integer ALU and other exu units.
// Holds the one-hot opcode bit positions, the uop / writeback payload structs
// and the ROB age compare used by every unit that honours redirect flushes.
package alu_pipe_pkg;

    localparam int unsigned XLEN_MAX   = 64;
    localparam int unsigned ALU_OP_W   = 11;
    localparam int unsigned PKG_ROB_W  = 6;
    localparam int unsigned PKG_PREG_W = 7;

    // One-hot opcode bit positions
    localparam int unsigned ALU_ADD   = 0;
    localparam int unsigned ALU_SLT   = 1;
    localparam int unsigned ALU_XOR   = 2;
    localparam int unsigned ALU_OR    = 3;
    localparam int unsigned ALU_AND   = 4;
    localparam int unsigned ALU_SLL   = 5;
    localparam int unsigned ALU_SRL   = 6;
    localparam int unsigned ALU_SRA   = 7;
    localparam int unsigned ALU_SUB   = 8;
    localparam int unsigned ALU_LUI   = 9;
    localparam int unsigned ALU_AUIPC = 10;

    // {wrap, idx}
    typedef logic [PKG_ROB_W:0] robidx_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0]   src1;
        logic [XLEN_MAX-1:0]   src2;
        logic [XLEN_MAX-1:0]   imm;
        logic [XLEN_MAX-1:0]   pc;
        logic [ALU_OP_W-1:0]   alu_type;
        logic                  is_word;
        logic                  is_unsigned;
        logic                  is_imm;
        robidx_t               robidx;
        logic [PKG_PREG_W-1:0] prd;
    } alu_uop_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0]   result;
        robidx_t               robidx;
        logic [PKG_PREG_W-1:0] prd;
        logic                  illegal;
    } alu_wb_t;

    // True when a is younger than f; the wrap bit flips the index order
    function automatic logic rob_is_younger(input robidx_t a, input robidx_t f);
        if (a[PKG_ROB_W] == f[PKG_ROB_W]) begin
            return a[PKG_ROB_W-1:0] > f[PKG_ROB_W-1:0];
        end
        return a[PKG_ROB_W-1:0] < f[PKG_ROB_W-1:0];
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational integer ALU core.
// Ports:
//   uop_i     - decoded ALU micro-op (operands, one-hot opcode, modifiers)
//   result_o  - XLEN-bit result, 0 for an illegal opcode
//   illegal_o - alu_type was not one-hot
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  alu_uop_t        uop_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [ALU_OP_W-1:0] t;
    logic [XLEN-1:0]     src1, src2, imm, pc;
    logic [XLEN-1:0]     op1, op2, sum, diff;
    logic [XLEN-1:0]     sll, srl, sra;
    logic [31:0]         sllw, srlw, sraw;
    logic [SHW-1:0]      shamt;
    logic                is_word, slt;
    logic                unused_fields;

    // Sign-extend a 32-bit word result to XLEN
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    assign unused_fields = ^{uop_i.robidx, uop_i.prd};

    // Operand selection and shared arithmetic
    always_comb begin
        t       = uop_i.alu_type;
        src1    = uop_i.src1[XLEN-1:0];
        src2    = uop_i.src2[XLEN-1:0];
        imm     = uop_i.imm[XLEN-1:0];
        pc      = uop_i.pc[XLEN-1:0];
        is_word = uop_i.is_word & (XLEN == 64);
        op2     = (uop_i.is_imm | t[ALU_AUIPC]) ? imm : src2;
        op1     = t[ALU_AUIPC] ? pc : src1;
        sum     = op1 + op2;
        diff    = src1 - op2;
        shamt   = is_word ? SHW'(op2[4:0]) : op2[SHW-1:0];
        slt     = uop_i.is_unsigned ? (src1 < op2) : ($signed(src1) < $signed(op2));
        sll     = src1 << shamt;
        srl     = src1 >> shamt;
        sra     = $signed(src1) >>> shamt;
        sllw    = src1[31:0] << shamt[4:0];
        srlw    = src1[31:0] >> shamt[4:0];
        sraw    = $signed(src1[31:0]) >>> shamt[4:0];
    end

    // Result select; opcode is one-hot so at most one branch applies
    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        if (!$onehot(t)) begin
            illegal_o = 1'b1;
        end else if (t[ALU_ADD]) begin
            result_o = is_word ? sext32(sum[31:0]) : sum;
        end else if (t[ALU_SUB]) begin
            result_o = is_word ? sext32(diff[31:0]) : diff;
        end else if (t[ALU_SLT]) begin
            result_o = XLEN'(slt);
        end else if (t[ALU_XOR]) begin
            result_o = src1 ^ op2;
        end else if (t[ALU_OR]) begin
            result_o = src1 | op2;
        end else if (t[ALU_AND]) begin
            result_o = src1 & op2;
        end else if (t[ALU_SLL]) begin
            result_o = is_word ? sext32(sllw) : sll;
        end else if (t[ALU_SRL]) begin
            result_o = is_word ? sext32(srlw) : srl;
        end else if (t[ALU_SRA]) begin
            result_o = is_word ? sext32(sraw) : sra;
        end else if (t[ALU_LUI]) begin
            result_o = imm;
        end else begin
            result_o = sum;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer ALU execution unit with valid/ready backpressure and
// ROB-based redirect flush.
// Ports:
//   clock, reset                       - clock and async active-high reset
//   in_valid/in_ready                  - input handshake
//   src1, src2, imm, pc, alu_type,
//   is_word, is_unsigned, is_imm       - micro-op operands and opcode
//   in_robidx, in_prd                  - ROB index and destination preg
//   flush_valid, flush_robidx          - redirect flush; squashes younger ops
//   out_valid/out_ready                - writeback handshake
//   out_result, out_robidx, out_prd,
//   out_illegal                        - writeback payload from the last stage
//   busy                               - any stage holds a valid op
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned ROB_W      = 6,
    parameter int unsigned PREG_W     = 7,
    parameter int unsigned ALU_TYPE_W = 11
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       src1,
    input  logic [XLEN-1:0]       src2,
    input  logic [XLEN-1:0]       imm,
    input  logic [XLEN-1:0]       pc,
    input  logic [ALU_TYPE_W-1:0] alu_type,
    input  logic                  is_word,
    input  logic                  is_unsigned,
    input  logic                  is_imm,
    input  logic [ROB_W:0]        in_robidx,
    input  logic [PREG_W-1:0]     in_prd,
    input  logic                  flush_valid,
    input  logic [ROB_W:0]        flush_robidx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [ROB_W:0]        out_robidx,
    output logic [PREG_W-1:0]     out_prd,
    output logic                  out_illegal,
    output logic                  busy
);

    localparam int unsigned LAST = PIPE_DEPTH - 1;

    alu_uop_t        uop;
    logic [XLEN-1:0] core_result;
    logic            core_illegal;
    robidx_t         in_rob, flush_rob;
    logic            in_kill;

    logic    valid_q [PIPE_DEPTH];
    logic    valid_d [PIPE_DEPTH];
    alu_wb_t data_q  [PIPE_DEPTH];
    alu_wb_t data_d  [PIPE_DEPTH];
    logic    kill    [PIPE_DEPTH];
    logic    rdy     [PIPE_DEPTH+1];

    // Keep the wrap bit at the package wrap position when ROB_W is narrower
    function automatic robidx_t rob_to_pkg(input logic [ROB_W:0] r);
        return {r[ROB_W], PKG_ROB_W'(r[ROB_W-1:0])};
    endfunction

    // Input micro-op packing
    always_comb begin
        uop             = '0;
        uop.src1        = XLEN_MAX'(src1);
        uop.src2        = XLEN_MAX'(src2);
        uop.imm         = XLEN_MAX'(imm);
        uop.pc          = XLEN_MAX'(pc);
        uop.alu_type    = ALU_OP_W'(alu_type);
        uop.is_word     = is_word;
        uop.is_unsigned = is_unsigned;
        uop.is_imm      = is_imm;
        uop.robidx      = rob_to_pkg(in_robidx);
        uop.prd         = PKG_PREG_W'(in_prd);
    end

    alu_pipe_core #(
        .XLEN (XLEN)
    ) u_core (
        .uop_i     (uop),
        .result_o  (core_result),
        .illegal_o (core_illegal)
    );

    // Handshake, flush and stage advance
    always_comb begin
        in_rob    = rob_to_pkg(in_robidx);
        flush_rob = rob_to_pkg(flush_robidx);
        in_kill   = flush_valid & rob_is_younger(in_rob, flush_rob);

        rdy[PIPE_DEPTH] = out_ready;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            rdy[k] = ~valid_q[k] | rdy[k+1];
        end

        busy = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            kill[k]    = flush_valid & rob_is_younger(data_q[k].robidx, flush_rob);
            valid_d[k] = valid_q[k] & ~kill[k];
            data_d[k]  = data_q[k];
            busy       = busy | valid_q[k];
        end

        // Stage 1 loads from the core; a flushed input is accepted but not written
        if (rdy[0]) begin
            valid_d[0] = in_valid & ~in_kill;
            if (in_valid & ~in_kill) begin
                data_d[0].result  = XLEN_MAX'(core_result);
                data_d[0].robidx  = in_rob;
                data_d[0].prd     = PKG_PREG_W'(in_prd);
                data_d[0].illegal = core_illegal;
            end
        end

        // Later stages take the upstream entry when they can move
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (rdy[k]) begin
                valid_d[k] = valid_q[k-1] & ~kill[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end

        in_ready  = rdy[0];
        out_valid = valid_q[LAST] & ~kill[LAST];
    end

    assign out_result  = data_q[LAST].result[XLEN-1:0];
    assign out_robidx  = {data_q[LAST].robidx[PKG_ROB_W], data_q[LAST].robidx[ROB_W-1:0]};
    assign out_prd     = data_q[LAST].prd[PREG_W-1:0];
    assign out_illegal = data_q[LAST].illegal;

    // Stage registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (XLEN=64, PIPE_DEPTH=2): directed steps
// feed a scoreboard queue that a negedge monitor drains on each handshake.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [63:0] src1, src2, imm, pc;
    logic [10:0] alu_type;
    logic        is_word, is_unsigned, is_imm;
    logic [6:0]  in_robidx, in_prd;
    logic        flush_valid;
    logic [6:0]  flush_robidx;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic [6:0]  out_robidx, out_prd;
    logic        out_illegal, busy;

    typedef struct {
        logic [63:0] res;
        logic [6:0]  rob;
        logic [6:0]  prd;
        logic        ill;
        bit          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_ret = 0;
    int   cyc = 0;
    int   base;

    alu_pipe #(
        .XLEN(64), .PIPE_DEPTH(2), .ROB_W(6), .PREG_W(7), .ALU_TYPE_W(11)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .imm(imm), .pc(pc),
        .alu_type(alu_type), .is_word(is_word), .is_unsigned(is_unsigned), .is_imm(is_imm),
        .in_robidx(in_robidx), .in_prd(in_prd),
        .flush_valid(flush_valid), .flush_robidx(flush_robidx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_robidx(out_robidx), .out_prd(out_prd),
        .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [10:0] oh(input int unsigned b);
        return 11'(1) << b;
    endfunction

    function automatic bit younger(input logic [6:0] a, input logic [6:0] f);
        if (a[6] == f[6]) return a[5:0] > f[5:0];
        return a[5:0] < f[5:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Writeback monitor: every handshake pops and checks the oldest expectation
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("robidx", 64'(out_robidx), 64'(e.rob));
                chk("prd", 64'(out_prd), 64'(e.prd));
                chk("illegal", 64'(out_illegal), 64'(e.ill));
                if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
            end
            n_ret++;
        end
    end

    // Present one op at posedge+1 and hold it until accepted (bounded)
    task automatic send(input logic [10:0] t, input logic [63:0] s1, input logic [63:0] s2,
                        input logic [63:0] im, input logic [63:0] p, input bit w, input bit u,
                        input bit ii, input logic [6:0] rob, input logic [6:0] prd,
                        input logic [63:0] er, input bit ei, input bit lat);
        bit done;
        exp_t e;
        done = 0;
        in_valid = 1; alu_type = t; src1 = s1; src2 = s2; imm = im; pc = p;
        is_word = w; is_unsigned = u; is_imm = ii; in_robidx = rob; in_prd = prd;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (in_ready) begin
                e = '{res: er, rob: rob, prd: prd, ill: ei, lat: lat, acc: cyc};
                sb.push_back(e);
                done = 1;
            end
            @(posedge clock); #1;
        end
        chk("send_accepted", 64'(done), 64'd1);
        in_valid = 0;
    endtask

    // One flush cycle with out_ready=1, optionally presenting an input op
    task automatic flush_step(input logic [6:0] f, input bit in_v, input logic [6:0] rob,
                              input bit exp_ov);
        exp_t e;
        flush_valid = 1; flush_robidx = f; out_ready = 1;
        in_valid = in_v; alu_type = oh(ALU_ADD); src1 = 64'd1; src2 = 64'd2;
        is_word = 0; is_unsigned = 0; is_imm = 0; in_robidx = rob; in_prd = 7'd99;
        @(negedge clock);
        chk("flush_out_valid", 64'(out_valid), 64'(exp_ov));
        if (in_v && in_ready && !younger(rob, f)) begin
            e = '{res: 64'd3, rob: rob, prd: 7'd99, ill: 1'b0, lat: 1'b0, acc: cyc};
            sb.push_back(e);
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (younger(sb[i].rob, f)) sb.delete(i);
        end
        @(posedge clock); #1;
        flush_valid = 0; in_valid = 0;
    endtask

    task automatic wait_drain(input string tag);
        bit ok;
        ok = 0;
        out_ready = 1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (sb.size() == 0 && !busy) ok = 1;
            else begin @(posedge clock); #1; end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; in_valid = 0; src1 = 0; src2 = 0; imm = 0; pc = 0; alu_type = 0;
        is_word = 0; is_unsigned = 0; is_imm = 0; in_robidx = 0; in_prd = 0;
        flush_valid = 0; flush_robidx = 0; out_ready = 1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_robidx", 64'(out_robidx), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 0;

        // Arithmetic, compare, shift, misc ops back-to-back
        send(oh(ALU_ADD), 64'h7FFF_FFFF, 64'd1, 0, 0, 1, 0, 0, 7'd1, 7'd11,
             64'hFFFF_FFFF_8000_0000, 0, 1);
        send(oh(ALU_SUB), 64'd5, 64'd7, 0, 0, 0, 0, 0, 7'd2, 7'd12,
             64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
        send(oh(ALU_SLT), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 0, 0, 7'd3, 7'd13, 64'd1, 0, 1);
        send(oh(ALU_SLT), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 1, 0, 7'd4, 7'd14, 64'd0, 0, 1);
        send(oh(ALU_SRA), 64'h8000_0000, 0, 64'd4, 0, 1, 0, 1, 7'd5, 7'd15,
             64'hFFFF_FFFF_F800_0000, 0, 1);
        send(oh(ALU_SRL), 64'h8000_0000_0000_0000, 0, 64'd63, 0, 0, 0, 1, 7'd6, 7'd16, 64'd1, 0, 1);
        send(oh(ALU_SLL), 64'd1, 64'd31, 0, 0, 1, 0, 0, 7'd7, 7'd17, 64'hFFFF_FFFF_8000_0000, 0, 1);
        send(oh(ALU_SRL), 64'hFFFF_FFFF_8000_0000, 64'd4, 0, 0, 1, 0, 0, 7'd8, 7'd18,
             64'h0000_0000_0800_0000, 0, 1);
        send(oh(ALU_XOR), 64'hF0F0, 64'h0FF0, 0, 0, 1, 0, 0, 7'd9, 7'd19, 64'hFF00, 0, 1);
        send(oh(ALU_AND), 64'hF0F0, 0, 64'h0FF0, 0, 0, 0, 1, 7'd10, 7'd20, 64'h00F0, 0, 1);
        send(oh(ALU_LUI), 64'd77, 0, 64'h1234_5000, 0, 0, 0, 1, 7'd11, 7'd21, 64'h1234_5000, 0, 1);
        send(oh(ALU_AUIPC), 64'd77, 64'd5, 64'h20, 64'h1000, 0, 0, 0, 7'd12, 7'd22, 64'h1020, 0, 1);
        send(11'b11, 64'd3, 64'd4, 0, 0, 0, 0, 0, 7'd13, 7'd23, 64'd0, 1, 1);
        send(11'b0, 64'd3, 64'd4, 0, 0, 0, 0, 0, 7'd14, 7'd24, 64'd0, 1, 1);
        wait_drain("drain_ops");

        // Backpressure: 6 ops with out_ready low for 3 cycles
        base = n_ret;
        out_ready = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(oh(ALU_ADD), 64'(i * 3), 64'd100, 0, 0, 0, 0, 0, 7'(20 + i), 7'(40 + i),
                         64'(i * 3 + 100), 0, 0);
            end
            begin
                @(negedge clock);
                chk("bp_ready_empty", 64'(in_ready), 64'd1);
                @(negedge clock);
                @(negedge clock);
                chk("bp_ready_full", 64'(in_ready), 64'd0);
                chk("bp_busy", 64'(busy), 64'd1);
                @(posedge clock); #1 out_ready = 1;
            end
        join
        wait_drain("drain_bp");
        chk("bp_retired", 64'(n_ret - base), 64'd6);

        // Flush: {0,5} and {0,9} in flight, input {0,12}, flush {0,7}
        base = n_ret;
        out_ready = 0;
        send(oh(ALU_ADD), 64'd50, 64'd5, 0, 0, 0, 0, 0, 7'd5, 7'd30, 64'd55, 0, 0);
        send(oh(ALU_ADD), 64'd90, 64'd9, 0, 0, 0, 0, 0, 7'd9, 7'd31, 64'd99, 0, 0);
        flush_step(7'd7, 1, 7'd12, 1);
        wait_drain("drain_flush1");
        chk("flush1_retired", 64'(n_ret - base), 64'd1);

        // Wrap: {0,60} survives flush {1,2}, {1,5} is squashed
        base = n_ret;
        out_ready = 0;
        send(oh(ALU_OR), 64'h100, 64'h1, 0, 0, 0, 0, 0, 7'd60, 7'd32, 64'h101, 0, 0);
        send(oh(ALU_OR), 64'h200, 64'h2, 0, 0, 0, 0, 0, 7'h45, 7'd33, 64'h202, 0, 0);
        flush_step(7'h42, 0, 7'd0, 1);
        wait_drain("drain_flush2");
        chk("flush2_retired", 64'(n_ret - base), 64'd1);

        // Younger entry at the last stage: out_valid masked in the flush cycle
        base = n_ret;
        out_ready = 0;
        send(oh(ALU_ADD), 64'd1, 64'd1, 0, 0, 0, 0, 0, 7'd20, 7'd34, 64'd2, 0, 0);
        @(posedge clock); #1;
        flush_step(7'd10, 0, 7'd0, 0);
        wait_drain("drain_flush3");
        chk("flush3_retired", 64'(n_ret - base), 64'd0);

        // Async reset mid-stream with both stages full
        out_ready = 0;
        send(oh(ALU_ADD), 64'h11, 64'h22, 0, 0, 0, 0, 0, 7'd3, 7'd5, 64'h33, 0, 0);
        send(oh(ALU_ADD), 64'h11, 64'h23, 0, 0, 0, 0, 0, 7'd4, 7'd6, 64'h34, 0, 0);
        #2 reset = 1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_result", out_result, 64'd0);
        chk("arst_out_robidx", 64'(out_robidx), 64'd0);
        chk("arst_out_prd", 64'(out_prd), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        sb.delete();
        @(posedge clock); #1;
        reset = 0;
        out_ready = 1;
        base = n_ret;
        send(oh(ALU_ADD), 64'd40, 64'd2, 0, 0, 0, 0, 0, 7'd1, 7'd2, 64'd42, 0, 1);
        wait_drain("drain_post_reset");
        chk("post_reset_retired", 64'(n_ret - base), 64'd1);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
